// File: rtl/traffic_phase_sched.sv
// Two-street intersection phase scheduler: green/yellow/all-red per street,
// sensor-driven green length, and a pedestrian walk phase that is served
// after whichever clearance comes first once a request is pending.
//
// state   | meaning
// --------+-----------------------------------------------------------
// A_GRN   | street A green, B red; ends on MIN/MAX green and ta_i
// A_YEL   | street A yellow, B red
// A_CLR   | all red after A; goes to WALK if a request is pending
// B_GRN   | street B green, A red; ends on MIN/MAX green and tb_i
// B_YEL   | street B yellow, A red
// B_CLR   | all red after B; goes to WALK if a request is pending
// WALK    | all red, walk lamp on; then green of the street not last served
module traffic_phase_sched #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 6,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ta_i,
    input  logic             tb_i,
    input  logic             ped_req_i,
    output logic [1:0]       la_o,
    output logic [1:0]       lb_o,
    output logic             walk_o,
    output logic             ped_ack_o,
    output logic [2:0]       phase_o
);

    typedef enum logic [2:0] {
        P_A_GRN = 3'd0,
        P_A_YEL = 3'd1,
        P_A_CLR = 3'd2,
        P_B_GRN = 3'd3,
        P_B_YEL = 3'd4,
        P_B_CLR = 3'd5,
        P_WALK  = 3'd6
    } phase_t;

    localparam logic [1:0] LAMP_GRN = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_RED = 2'b10;

    // Last timer value of each interval (timer counts from 0)
    localparam logic [CNT_W-1:0] MIN_G_T = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_G_T = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] CLR_T   = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_T  = CNT_W'(WALK - 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             next_street;      // 1: B is served after the walk
    logic             next_street_nxt;
    logic             enter_walk;

    // Next-phase selection; also records which street follows a walk
    always_comb begin
        phase_nxt       = phase;
        next_street_nxt = next_street;
        case (phase)
            P_A_GRN: if (timer >= MIN_G_T && (!ta_i || timer == MAX_G_T)) phase_nxt = P_A_YEL;
            P_A_YEL: if (timer == YEL_T) phase_nxt = P_A_CLR;
            P_A_CLR: if (timer == CLR_T) begin
                phase_nxt       = ped_pending ? P_WALK : P_B_GRN;
                next_street_nxt = 1'b1;
            end
            P_B_GRN: if (timer >= MIN_G_T && (!tb_i || timer == MAX_G_T)) phase_nxt = P_B_YEL;
            P_B_YEL: if (timer == YEL_T) phase_nxt = P_B_CLR;
            P_B_CLR: if (timer == CLR_T) begin
                phase_nxt       = ped_pending ? P_WALK : P_A_GRN;
                next_street_nxt = 1'b0;
            end
            P_WALK:  if (timer == WALK_T) phase_nxt = next_street ? P_B_GRN : P_A_GRN;
            default: phase_nxt = P_A_GRN;
        endcase
    end

    assign enter_walk = (phase_nxt == P_WALK) && (phase != P_WALK);

    // Phase, interval timer, pedestrian request latch and walk successor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= P_A_GRN;
            timer       <= '0;
            ped_pending <= 1'b0;
            next_street <= 1'b1;
        end else begin
            phase       <= phase_nxt;
            timer       <= (phase_nxt != phase) ? '0 : timer + CNT_W'(1);
            next_street <= next_street_nxt;
            // Entering WALK serves everything up to and including this edge
            if (enter_walk)
                ped_pending <= 1'b0;
            else if (ped_req_i)
                ped_pending <= 1'b1;
        end
    end

    // Moore decode of lamps and status
    always_comb begin
        la_o      = LAMP_RED;
        lb_o      = LAMP_RED;
        walk_o    = 1'b0;
        ped_ack_o = 1'b0;
        phase_o   = phase;
        case (phase)
            P_A_GRN: la_o = LAMP_GRN;
            P_A_YEL: la_o = LAMP_YEL;
            P_B_GRN: lb_o = LAMP_GRN;
            P_B_YEL: lb_o = LAMP_YEL;
            P_WALK: begin
                walk_o    = 1'b1;
                ped_ack_o = (timer == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: a cycle-level reference model
// pushes expected outputs, a negedge monitor pops and compares.
module tb_traffic_phase_sched;

    localparam int MIN_GREEN = 8;
    localparam int MAX_GREEN = 32;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 1;
    localparam int WALK      = 6;
    localparam int CNT_W     = 6;

    localparam int A_GRN = 0, A_YEL = 1, A_CLR = 2, B_GRN = 3, B_YEL = 4, B_CLR = 5, PH_WALK = 6;

    logic       clk;
    logic       rst_n;
    logic       ta_s, tb_s, ped_req;
    logic [1:0] la_o, lb_o;
    logic       walk_o, ped_ack_o;
    logic [2:0] phase_o;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];

    // reference model state
    int m_ph;
    int m_t;
    bit m_pend;
    bit m_next_b;

    traffic_phase_sched #(
        .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW(YELLOW),
        .ALL_RED(ALL_RED), .WALK(WALK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ta_i(ta_s), .tb_i(tb_s), .ped_req_i(ped_req),
        .la_o(la_o), .lb_o(lb_o), .walk_o(walk_o), .ped_ack_o(ped_ack_o), .phase_o(phase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got phase=%0d la=%b lb=%b walk=%b ack=%b, expected phase=%0d la=%b lb=%b walk=%b ack=%b",
                     name, $time, got[8:6], got[5:4], got[3:2], got[1], got[0],
                     exp[8:6], exp[5:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_ph = A_GRN; m_t = 0; m_pend = 0; m_next_b = 1;
        exp_q.delete();
    endtask

    function automatic logic [8:0] model_out();
        logic [1:0] la, lb;
        la = (m_ph == A_GRN) ? 2'b00 : (m_ph == A_YEL) ? 2'b01 : 2'b10;
        lb = (m_ph == B_GRN) ? 2'b00 : (m_ph == B_YEL) ? 2'b01 : 2'b10;
        return {3'(m_ph), la, lb, 1'(m_ph == PH_WALK), 1'(m_ph == PH_WALK && m_t == 0)};
    endfunction

    // One clock of the intersection rules: how long each interval lasts and where it goes
    task automatic model_step(input bit ta, input bit tb, input bit req);
        bit done;
        int nph;
        done = 0;
        nph  = m_ph;
        case (m_ph)
            A_GRN, B_GRN: begin
                int elapsed;
                bit traffic;
                elapsed = m_t + 1;
                traffic = (m_ph == A_GRN) ? ta : tb;
                done = (elapsed >= MIN_GREEN) && (!traffic || elapsed == MAX_GREEN);
                nph  = m_ph + 1;
            end
            A_YEL, B_YEL: begin
                done = (m_t + 1 == YELLOW);
                nph  = m_ph + 1;
            end
            A_CLR, B_CLR: begin
                done = (m_t + 1 == ALL_RED);
                nph  = m_pend ? PH_WALK : ((m_ph == A_CLR) ? B_GRN : A_GRN);
            end
            default: begin
                done = (m_t + 1 == WALK);
                nph  = m_next_b ? B_GRN : A_GRN;
            end
        endcase
        if (done && m_ph == A_CLR) m_next_b = 1;
        if (done && m_ph == B_CLR) m_next_b = 0;
        if (done && nph == PH_WALK) m_pend = 0;
        else if (req) m_pend = 1;
        if (done) begin
            m_ph = nph;
            m_t  = 0;
        end else begin
            m_t++;
        end
    endtask

    // model advances on every live clock edge and queues the expected outputs
    always @(posedge clk) begin
        if (rst_n) begin
            model_step(ta_s, tb_s, ped_req);
            exp_q.push_back(model_out());
        end
    end

    // monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0)
            check("cycle", {phase_o, la_o, lb_o, walk_o, ped_ack_o}, exp_q.pop_front());
    end

    task automatic wait_state(input int ph, input int t);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_ph == ph && m_t == t) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_state phase=%0d t=%0d not reached, model at phase=%0d t=%0d", ph, t, m_ph, m_t);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // asynchronous reset mid-cycle: outputs must settle before the next edge
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, {phase_o, la_o, lb_o, walk_o, ped_ack_o}, {3'd0, 2'b00, 2'b10, 1'b0, 1'b0});
        model_reset();
        ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        ta_s = 0; tb_s = 0; ped_req = 0;
        model_reset();
        #3 rst_n = 1'b0;
        #1 check("reset", {phase_o, la_o, lb_o, walk_o, ped_ack_o}, {3'd0, 2'b00, 2'b10, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // idle cycling
        run(60);

        // traffic held on both streets: max green
        ta_s = 1; tb_s = 1;
        run(100);

        // ta drops early (ignored until min green) and late
        wait_state(A_GRN, 3);
        ta_s = 0; tb_s = 0;
        wait_state(A_GRN, 0);
        ta_s = 1;
        wait_state(A_GRN, 20);
        ta_s = 0;

        // single pedestrian pulse
        wait_state(A_GRN, 2);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        run(40);

        // request held across the walk entry edge: one walk only
        wait_state(A_GRN, 1);
        ped_req = 1;
        wait_state(PH_WALK, 0);
        ped_req = 0;
        run(40);

        // request during walk: a second walk follows next clearance
        wait_state(B_GRN, 1);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        wait_state(PH_WALK, 3);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        run(60);

        // reset during B_YEL with a request pending
        wait_state(B_GRN, 2);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        wait_state(B_YEL, 1);
        async_reset("reset_in_b_yel");
        run(50);

        // reset during WALK with another request pending
        wait_state(A_GRN, 1);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        wait_state(PH_WALK, 3);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        async_reset("reset_in_walk");
        run(50);

        // random traffic and pedestrian activity
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) ta_s = ~ta_s;
            if ($urandom_range(0, 9) == 0) tb_s = ~tb_s;
            ped_req = ($urandom_range(0, 29) == 0);
        end
        ped_req = 0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Timed phase scheduler for a two-street intersection. It sequences green, yellow and all-red intervals for street A and street B. Each interval is timed by a cycle counter. Minimum and maximum green times depend on the traffic sensors. An all-red clearance interval follows every yellow. A pedestrian walk phase is served through a request/acknowledge handshake. The block drives the intersection lamps directly and exposes its current phase for status logic.

## Interface
- MIN_GREEN, 8: minimum cycles a street stays green (>=1)
- MAX_GREEN, 32: cycles after which green ends even with traffic present (>=MIN_GREEN)
- YELLOW, 3: yellow duration in cycles (>=1)
- ALL_RED, 1: all-red clearance duration in cycles (>=1)
- WALK, 6: pedestrian walk duration in cycles (>=1)
- CNT_W, 6: phase timer width; 2^CNT_W > max(MAX_GREEN, YELLOW, ALL_RED, WALK)
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ta_i  in  1  traffic present on street A
- tb_i  in  1  traffic present on street B
- ped_req_i  in  1  pedestrian request, level or single-cycle pulse
- la_o  out  2  street A lamp: green=2'b00, yellow=2'b01, red=2'b10
- lb_o  out  2  street B lamp, same encoding
- walk_o  out  1  pedestrian walk lamp
- ped_ack_o  out  1  single-cycle acknowledge of a served request
- phase_o  out  3  current phase encoding

## Operation
- Phases and their phase_o encoding:
  - A_GRN=0
  - A_YEL=1
  - A_CLR=2
  - B_GRN=3
  - B_YEL=4
  - B_CLR=5
  - WALK=6
- phase_o value 7 is illegal and recovers to A_GRN on the next edge.
- Lamps are a Moore decode of the phase:
  - A_GRN: la=green, lb=red
  - A_YEL: la=yellow, lb=red
  - B_GRN: la=red, lb=green
  - B_YEL: la=red, lb=yellow
  - A_CLR, B_CLR and WALK: both red
  - walk_o=1 only in WALK.
- Timer: CNT_W-bit counter, cleared to 0 on every phase entry, increments each cycle in the phase. It never wraps, because every phase exits at or before its limit.
- Transitions, with t = timer value in the current cycle:
  - A_GRN -> A_YEL when t >= MIN_GREEN-1 and (ta_i==0 or t==MAX_GREEN-1).
  - A_YEL -> A_CLR at t==YELLOW-1.
  - A_CLR at t==ALL_RED-1 -> WALK if ped_pending, else B_GRN.
  - B_GRN, B_YEL and B_CLR mirror the A phases, using tb_i; B_CLR exits to WALK or A_GRN.
  - WALK at t==WALK-1 -> green of the street after the one that last cleared (A_CLR -> B_GRN, B_CLR -> A_GRN). A 1-bit next_street register holds this.
- ped_pending:
  - Set by ped_req_i==1 in any cycle.
  - Cleared on the edge that enters WALK.
  - A request sampled on that same edge is absorbed, i.e. counts as served; clear wins.
  - A request during WALK (after the entry cycle) sets pending again; it is served at the next clearance.
- ped_ack_o = 1 exactly in the first WALK cycle (t==0).
- Sensors are sampled only in green phases. A drop of ta_i/tb_i before MIN_GREEN is ignored.

## Timing
- Reset (async assert):
  - phase=A_GRN, timer=0, ped_pending=0, next_street=B.
  - Outputs: la_o=00, lb_o=10, walk_o=0, ped_ack_o=0, phase_o=0.
  - All take effect immediately, without waiting for a clock edge.
- Reset mid-phase (any phase, including WALK): an immediate return to the reset values above. A pending request is lost.
- Deassertion: the first edge after rst_n rises counts as timer cycle 0 of A_GRN.
- Phase duration in cycles:
  - Green: MIN_GREEN..MAX_GREEN.
  - Yellow: YELLOW.
  - Clearance: ALL_RED.
  - Walk: WALK.
- Default idle cycle with ta_i=tb_i=0 and no requests: 8+3+1+8+3+1 = 24 cycles.
- Outputs change only on the edge ending the last cycle of a phase; no glitches between phases.

## Test plan
- Defaults, ta_i=tb_i=0, ped_req_i=0, release reset -> la_o=00 cycles 0-7, 01 cycles 8-10, both red cycle 11, lb_o=00 cycles 12-19; phase_o sequence 0,1,2,3,4,5 repeats every 24 cycles.
- ta_i=1 held -> A_GRN lasts exactly 32 cycles, then A_YEL; with tb_i=1 held, B_GRN also lasts 32 cycles.
- ta_i=1 dropped to 0 at t=3 of A_GRN -> A_YEL entered after t=7, i.e. green is 8 cycles; drop at t=20 -> A_YEL after t=20.
- One-cycle ped_req_i pulse at A_GRN t=2 -> after A_CLR: WALK for 6 cycles, walk_o=1, la_o=lb_o=10, ped_ack_o=1 only in the first WALK cycle, then B_GRN.
- ped_req_i held high through the WALK entry edge and dropped at WALK t=0 -> exactly one WALK, next clearance goes straight to green; ped_req_i pulse at WALK t=3 -> a second WALK after the next clearance.
- rst_n asserted asynchronously during B_YEL and during WALK -> outputs reach reset values before the next clk edge; pending request discarded; a normal 24-cycle sequence resumes after release.
